// File: rtl/conv5d_pkg.sv
// ============================================================================
// Module   : conv5d_pkg
// Brief    : FSM states, cs encodings and output-dimension helper for conv5d.
//            CONV5D_STRIDE2_EN selects a window step of 2.
// Revision : 1.0
// ============================================================================
`default_nettype none

package conv5d_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        MUL   = 3'd2,
        ADD   = 3'd3,
        EMIT  = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [1:0] CS_HOLD = 2'b00;
    localparam logic [1:0] CS_MUL  = 2'b01;
    localparam logic [1:0] CS_ADD  = 2'b10;

`ifdef CONV5D_STRIDE2_EN
    localparam int STRIDE = 2;
`else
    localparam int STRIDE = 1;
`endif

    function automatic int out_dim(input int img, input int k, input int stride);
        return (img - k) / stride + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/conv5d_coord_cnt.sv
// ============================================================================
// Module   : conv5d_coord_cnt
// Brief    : Output row/col counter pair with terminal flag and window-coord
//            scaling (x2 when CONV5D_STRIDE2_EN is defined).
// Revision : 1.0
// ============================================================================
`default_nettype none

module conv5d_coord_cnt #(
    parameter int OW = 24,
    parameter int OH = 24,
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          adv,
    output logic [CW-1:0] row,
    output logic [CW-1:0] col,
    output logic [CW-1:0] win_row,
    output logic [CW-1:0] win_col,
    output logic          last
);

    logic [CW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          col_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    // Advancing past the final position is suppressed so counters never wrap.
    always_comb begin
        col_last = (col_q == CW'(OW - 1));
        last     = col_last && (row_q == CW'(OH - 1));
        row_d    = row_q;
        col_d    = col_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
        end else if (adv && !last) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_q + CW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    assign row = row_q;
    assign col = col_q;

`ifdef CONV5D_STRIDE2_EN
    assign win_row = row_q << 1;
    assign win_col = col_q << 1;
`else
    assign win_row = row_q;
    assign win_col = col_q;
`endif

endmodule

`default_nettype wire

// File: rtl/conv5d_sched.sv
// ============================================================================
// Module   : conv5d_sched
// Brief    : Start/done scheduler for the 5x5 convolution datapath: fetches
//            each window, sequences cs and emits results under valid/ready.
//            CONV5D_STRIDE2_EN selects a window step of 2.
// Revision : 1.0
// ============================================================================
`default_nettype none

module conv5d_sched
    import conv5d_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int K     = 5,
    parameter int CW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          win_req,
    input  logic          win_ack,
    output logic [CW-1:0] win_row,
    output logic [CW-1:0] win_col,
    output logic [1:0]    cs,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_row,
    output logic [CW-1:0] out_col
);

    localparam int OW = out_dim(IMG_W, K, STRIDE);
    localparam int OH = out_dim(IMG_H, K, STRIDE);

    state_t state_q, state_d;
    logic   cnt_clr;
    logic   cnt_adv;
    logic   cnt_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs decode from state alone; handshake inputs only steer transitions.
    always_comb begin
        state_d   = state_q;
        cnt_clr   = 1'b0;
        cnt_adv   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        win_req   = 1'b0;
        out_valid = 1'b0;
        cs        = CS_HOLD;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    cnt_clr = 1'b1;
                end
            end
            FETCH: begin
                busy    = 1'b1;
                win_req = 1'b1;
                if (win_ack) begin
                    state_d = MUL;
                end
            end
            MUL: begin
                busy    = 1'b1;
                cs      = CS_MUL;
                state_d = ADD;
            end
            ADD: begin
                busy    = 1'b1;
                cs      = CS_ADD;
                state_d = EMIT;
            end
            EMIT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    if (cnt_last) begin
                        state_d = DONE;
                    end else begin
                        state_d = FETCH;
                        cnt_adv = 1'b1;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    conv5d_coord_cnt #(
        .OW (OW),
        .OH (OH),
        .CW (CW)
    ) u_coord_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .adv     (cnt_adv),
        .row     (out_row),
        .col     (out_col),
        .win_row (win_row),
        .win_col (win_col),
        .last    (cnt_last)
    );

endmodule

`default_nettype wire

// File: tb/tb_conv5d_sched.sv
// ============================================================================
// Module   : tb_conv5d_sched
// Brief    : Self-checking bench for conv5d_sched with a behavioural datapath
//            (weights 1, bias 3). Honours CONV5D_STRIDE2_EN (9x9 map, step 2).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_conv5d_sched;

`ifdef CONV5D_STRIDE2_EN
    localparam int IMG_W = 9;
    localparam int IMG_H = 9;
    localparam int S     = 2;
`else
    localparam int IMG_W = 7;
    localparam int IMG_H = 6;
    localparam int S     = 1;
`endif
    localparam int K  = 5;
    localparam int CW = 5;
    localparam int OW = (IMG_W - K) / S + 1;
    localparam int OH = (IMG_H - K) / S + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic          win_req;
    logic          win_ack;
    logic [CW-1:0] win_row;
    logic [CW-1:0] win_col;
    logic [1:0]    cs;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_row;
    logic [CW-1:0] out_col;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    conv5d_sched #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .K     (K),
        .CW    (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .win_req   (win_req),
        .win_ack   (win_ack),
        .win_row   (win_row),
        .win_col   (win_col),
        .cs        (cs),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_col   (out_col)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural datapath: 25 products (weight 1), adder tree plus bias 3.
    logic [7:0]  pix  [25];
    logic [15:0] prod [25];
    logic [7:0]  dp_out;

    function automatic logic [7:0] dp_sum();
        logic [15:0] s;
        s = 16'd3;
        for (int i = 0; i < 25; i++) s = s + prod[i];
        return s[7:0];
    endfunction

    always @(posedge clk) begin
        if (cs[0]) for (int i = 0; i < 25; i++) prod[i] <= {8'd0, pix[i]};
        if (cs[1]) dp_out <= dp_sum();
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},    int'(busy),      0);
        chk({tag, "_done"},    int'(done),      0);
        chk({tag, "_req"},     int'(win_req),   0);
        chk({tag, "_cs"},      int'(cs),        0);
        chk({tag, "_valid"},   int'(out_valid), 0);
        chk({tag, "_win_row"}, int'(win_row),   0);
        chk({tag, "_win_col"}, int'(win_col),   0);
        chk({tag, "_out_row"}, int'(out_row),   0);
        chk({tag, "_out_col"}, int'(out_col),   0);
    endtask

    // One full pass from IDLE. Results are expected in raster order of the
    // output map; abort_at >= 0 asserts rst in the ADD cycle of that result.
    task automatic run_pass(input int ack_lo, input int ack_hi, input int rdy_lo,
                            input int rdy_hi, input bit fixed_pix, input int abort_at);
        int  n, d, t0, sum, expv;
        bit  aborted;
        n = 0;
        aborted = 1'b0;
        expv = 0;
        chk("pre_idle_busy", int'(busy), 0);
        start = 1'b1;
        t0 = cyc;
        step();
        start = 1'b0;
        for (int r = 0; r < OH && !aborted; r++) begin
            for (int c = 0; c < OW && !aborted; c++) begin
                d = int'($urandom_range(ack_hi, ack_lo));
                for (int j = 0; j <= d; j++) begin
                    chk("fetch_req",   int'(win_req),   1);
                    chk("fetch_cs",    int'(cs),        0);
                    chk("fetch_valid", int'(out_valid), 0);
                    chk("fetch_busy",  int'(busy),      1);
                    chk("win_row",     int'(win_row),   r * S);
                    chk("win_col",     int'(win_col),   c * S);
                    start     = 1'($urandom_range(1, 0));
                    out_ready = 1'($urandom_range(1, 0));
                    if (j == d) begin
                        win_ack = 1'b1;
                        sum = 0;
                        for (int i = 0; i < 25; i++) begin
                            pix[i] = fixed_pix ? 8'd2 : 8'($urandom_range(255, 0));
                            sum += int'(pix[i]);
                        end
                        expv = (sum + 3) % 256;
                    end else begin
                        win_ack = 1'b0;
                    end
                    step();
                end
                win_ack   = 1'($urandom_range(1, 0));
                out_ready = 1'($urandom_range(1, 0));
                chk("mul_cs",  int'(cs),      1);
                chk("mul_req", int'(win_req), 0);
                step();
                chk("add_cs",    int'(cs),        2);
                chk("add_valid", int'(out_valid), 0);
                if (n == abort_at) begin
                    rst = 1'b1;
                    #1;
                    chk_all_zero("abort");
                    step();
                    rst       = 1'b0;
                    start     = 1'b0;
                    win_ack   = 1'b0;
                    out_ready = 1'b0;
                    aborted   = 1'b1;
                end else begin
                    step();
                    d = int'($urandom_range(rdy_hi, rdy_lo));
                    for (int j = 0; j <= d; j++) begin
                        chk("emit_valid", int'(out_valid), 1);
                        chk("emit_cs",    int'(cs),        0);
                        chk("emit_req",   int'(win_req),   0);
                        chk("emit_row",   int'(out_row),   r);
                        chk("emit_col",   int'(out_col),   c);
                        chk("emit_data",  int'(dp_out),    expv);
                        out_ready = (j == d);
                        win_ack   = 1'($urandom_range(1, 0));
                        start     = 1'($urandom_range(1, 0));
                        step();
                    end
                    n++;
                end
            end
        end
        if (!aborted) begin
            start     = 1'b0;
            win_ack   = 1'b0;
            out_ready = 1'b0;
            chk("done_pulse", int'(done),      1);
            chk("done_busy",  int'(busy),      0);
            chk("done_valid", int'(out_valid), 0);
            chk("done_cs",    int'(cs),        0);
            chk("result_cnt", n, OW * OH);
            if (ack_hi == 0 && rdy_hi == 0) chk("pass_latency", cyc - t0, 4 * OW * OH + 1);
            step();
            chk("post_done",  int'(done),    0);
            chk("post_busy",  int'(busy),    0);
            chk("post_req",   int'(win_req), 0);
            step();
            chk("stay_idle",  int'(busy),    0);
        end
    endtask

    typedef struct {
        bit start;
        bit ack;
        bit ready;
        bit busy;
        bit req;
        int cs;
        bit valid;
        bit done;
        int orow;
        int ocol;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit s, input bit a, input bit r, input bit b,
                                input bit q, input int c, input bit v, input bit d,
                                input int orow, input int ocol);
        vec_t e;
        e.start = s; e.ack = a; e.ready = r; e.busy = b; e.req = q;
        e.cs = c; e.valid = v; e.done = d; e.orow = orow; e.ocol = ocol;
        tbl.push_back(e);
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        win_ack   = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 25; i++) pix[i] = 8'd0;

        // Cycle table: first result immediate, then a 5-cycle stall on (0,1)
        // with stray start/ack/ready that must all be ignored.
        add(1, 1, 1,  0, 0, 0, 0, 0,  0, 0);
        add(0, 1, 1,  1, 1, 0, 0, 0,  0, 0);
        add(0, 0, 1,  1, 0, 1, 0, 0,  0, 0);
        add(0, 0, 0,  1, 0, 2, 0, 0,  0, 0);
        add(0, 0, 1,  1, 0, 0, 1, 0,  0, 0);
        add(1, 1, 0,  1, 1, 0, 0, 0,  0, 1);
        add(0, 1, 0,  1, 0, 1, 0, 0,  0, 1);
        add(0, 0, 1,  1, 0, 2, 0, 0,  0, 1);
        for (int i = 0; i < 5; i++) add(0, 1, 0,  1, 0, 0, 1, 0,  0, 1);
        add(0, 0, 1,  1, 0, 0, 1, 0,  0, 1);
        add(0, 0, 0,  1, 1, 0, 0, 0,  0, 2);
        add(0, 0, 0,  1, 1, 0, 0, 0,  0, 2);

        step();
        step();
        chk_all_zero("reset");
        rst = 1'b0;
        step();
        chk_all_zero("idle");

        for (int i = 0; i < tbl.size(); i++) begin
            chk($sformatf("t%0d_busy", i),  int'(busy),      int'(tbl[i].busy));
            chk($sformatf("t%0d_req", i),   int'(win_req),   int'(tbl[i].req));
            chk($sformatf("t%0d_cs", i),    int'(cs),        tbl[i].cs);
            chk($sformatf("t%0d_valid", i), int'(out_valid), int'(tbl[i].valid));
            chk($sformatf("t%0d_done", i),  int'(done),      int'(tbl[i].done));
            chk($sformatf("t%0d_orow", i),  int'(out_row),   tbl[i].orow);
            chk($sformatf("t%0d_ocol", i),  int'(out_col),   tbl[i].ocol);
            chk($sformatf("t%0d_wcol", i),  int'(win_col),   tbl[i].ocol * S);
            start     = tbl[i].start;
            win_ack   = tbl[i].ack;
            out_ready = tbl[i].ready;
            step();
        end

        rst = 1'b1;
        start = 1'b0;
        win_ack = 1'b0;
        out_ready = 1'b0;
        #1;
        chk_all_zero("tbl_rst");
        step();
        rst = 1'b0;
        step();

        run_pass(0, 0, 0, 0, 1'b1, -1);
        run_pass(3, 3, 0, 0, 1'b0, -1);
        run_pass(0, 0, 0, 0, 1'b0, OW + 1);
        chk_all_zero("after_abort");
        run_pass(0, 0, 0, 0, 1'b0, -1);
        for (int k = 0; k < 3; k++) run_pass(0, 3, 0, 3, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
